neopixel_driver: RTL and testbench

- SPI slave that receives a frame of 24-bit pixel words and stores them in an internal buffer.
- When the frame ends, it replays the stored words one per clock on a parallel pixel bus, with a "flushing" qualifier.
- Sits between a host SPI master and the downstream NeoPixel serialiser, which consumes pixels while flushing is high.

---
 rtl/neopixel_driver.sv | 90 +++++++++
 tb/tb_neopixel_driver.sv | 123 ++++++++++++
 2 files changed

// File: rtl/neopixel_driver.sv
// neopixel_driver: SPI-slave frame buffer that replays received 24-bit pixel words one per clk.
module neopixel_driver #(
  parameter int NUM_PIXELS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs,
  output logic [23:0] pixels,
  output logic        flushing
);
  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam int AW = NUM_PIXELS > 1 ? $clog2(NUM_PIXELS) : 1;
  typedef enum logic [1:0] {IDLE, RECEIVE, FLUSH} state_t;
  state_t      state;
  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  mosi_q;
  logic [4:0]  bcnt;
  logic [CW-1:0] wcnt, rd;
  logic [23:0] shreg;
  logic [23:0] mem [NUM_PIXELS];
  logic sclk_rise, cs_fall, cs_rise, bit_take, word_done;
  logic [23:0] shreg_next;
  logic [CW-1:0] wcnt_next;
  // [0],[1] synchronise; [2] is the delayed copy used for edge detection
  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign cs_fall    = ~cs_q[1] & cs_q[2];
  assign cs_rise    = cs_q[1] & ~cs_q[2];
  assign bit_take   = state == RECEIVE && sclk_rise && wcnt < CW'(NUM_PIXELS);
  assign word_done  = bit_take && bcnt == 5'd23;
  assign shreg_next = {shreg[22:0], mosi_q[1]};
  assign wcnt_next  = wcnt + CW'(word_done);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sclk_q   <= '0;
      cs_q     <= '0;
      mosi_q   <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      rd       <= '0;
      shreg    <= '0;
      pixels   <= '0;
      flushing <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs};
      mosi_q <= {mosi_q[0], mosi};
      case (state)
        IDLE: begin
          pixels   <= '0;
          flushing <= 1'b0;
          if (cs_fall) begin
            state <= RECEIVE;
            bcnt  <= '0;
            wcnt  <= '0;
            shreg <= '0;
          end
        end
        RECEIVE: begin
          if (bit_take) begin
            shreg <= shreg_next;
            bcnt  <= word_done ? 5'd0 : bcnt + 5'd1;
          end
          wcnt <= wcnt_next;
          // a bit landing on the same cycle as cs rise is counted before deciding
          if (cs_rise) begin
            state <= wcnt_next != '0 ? FLUSH : IDLE;
            rd    <= '0;
          end
        end
        FLUSH: begin
          if (rd < wcnt) begin
            pixels   <= mem[rd[AW-1:0]];
            flushing <= 1'b1;
            rd       <= rd + CW'(1);
          end else begin
            pixels   <= '0;
            flushing <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (word_done) mem[wcnt[AW-1:0]] <= shreg_next;
endmodule

// File: tb/tb_neopixel_driver.sv
// tb_neopixel_driver: random and directed SPI frames checked against a word-extraction model.
module tb_neopixel_driver;
  localparam int N = 3;
  logic clk = 0, reset = 0, sclk = 0, mosi = 0, cs = 1;
  logic [23:0] pixels;
  logic flushing;
  neopixel_driver #(.NUM_PIXELS(N)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs),
    .pixels(pixels), .flushing(flushing)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int cyc = 0, first_cyc = -1, rise_cyc = 0, runs = 0, bad_idle = 0;
  logic prev_fl = 0;
  logic [23:0] got_q[$];
  bit bq[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (flushing) begin
      got_q.push_back(pixels);
      if (!prev_fl) begin
        runs++;
        if (first_cyc < 0) first_cyc = cyc;
      end
    end else if (pixels != 0) bad_idle++;
    prev_fl = flushing;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic add_word(input logic [23:0] w);
    for (int b = 23; b >= 0; b--) bq.push_back(w[b]);
  endtask
  task automatic run_frame(input string tag, input bit coincide, input bit do_reset);
    int nw;
    logic [23:0] v;
    got_q.delete();
    first_cyc = -1;
    runs = 0;
    bad_idle = 0;
    cs = 0;
    tick(6);
    for (int i = 0; i < bq.size(); i++) begin
      mosi = bq[i];
      tick(5);
      sclk = 1;
      if (coincide && i == bq.size() - 1) begin
        cs = 1;
        rise_cyc = cyc;
      end
      tick(5);
      sclk = 0;
      if (do_reset && i == 47) begin
        reset = 0;
        tick(1);
        reset = 1;
      end
    end
    if (!coincide || bq.size() == 0) begin
      tick(5);
      cs = 1;
      rise_cyc = cyc;
    end
    tick(25);
    nw = do_reset ? 0 : (bq.size() / 24 < N ? bq.size() / 24 : N);
    check({tag, "_count"}, got_q.size(), nw);
    for (int w = 0; w < nw && w < got_q.size(); w++) begin
      v = 0;
      for (int b = 0; b < 24; b++) v = {v[22:0], bq[24 * w + b]};
      check($sformatf("%s_word%0d", tag, w), got_q[w], v);
    end
    check({tag, "_runs"}, runs, nw > 0 ? 1 : 0);
    if (nw > 0) check({tag, "_latency"}, first_cyc - rise_cyc, 4);
    check({tag, "_idle_pix"}, bad_idle, 0);
  endtask
  initial begin
    int n;
    bit co;
    reset = 0;
    tick(2);
    check("reset_pix", pixels, 0);
    check("reset_fl", flushing, 0);
    reset = 1;
    runs = 0;
    bad_idle = 0;
    tick(30);
    check("idle_runs", runs, 0);
    check("idle_pix", bad_idle, 0);
    bq.delete(); add_word(24'hFF0000); add_word(24'h00FF00); add_word(24'h0000FF);
    run_frame("full", 0, 0);
    bq.delete(); add_word(24'h123456);
    for (int i = 0; i < 5; i++) bq.push_back(1'($urandom));
    run_frame("partial", 0, 0);
    bq.delete(); add_word(24'h111111); add_word(24'h222222); add_word(24'h333333); add_word(24'h444444);
    run_frame("overflow", 0, 0);
    bq.delete();
    run_frame("empty0", 0, 0);
    for (int i = 0; i < 10; i++) bq.push_back(1'($urandom));
    run_frame("empty10", 0, 0);
    bq.delete(); add_word(24'hA5A5A5); add_word(24'h5A5A5A); add_word(24'hC3C3C3);
    run_frame("coincide", 1, 0);
    bq.delete(); add_word(24'hABCDEF); add_word(24'h0F0F0F);
    run_frame("reset_mid", 0, 1);
    bq.delete(); add_word(24'hDEAD01); add_word(24'hBEEF02); add_word(24'hCAFE03);
    run_frame("after_reset", 0, 0);
    for (int f = 0; f < 8; f++) begin
      bq.delete();
      n = $urandom_range(0, 100);
      for (int i = 0; i < n; i++) bq.push_back(1'($urandom));
      co = 1'($urandom);
      run_frame($sformatf("rand%0d", f), co, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
